// File: rtl/byte_stream_fifo_pkg.sv
// rtl/byte_stream_fifo_pkg.sv - shared sizes and types for the byte stream FIFO controller
package byte_stream_fifo_pkg;
  localparam int DEPTH  = 2048;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;
  localparam int MASK_W = 4;
  localparam int CNT_W  = 12;

  localparam logic [MASK_W-1:0] FULL_MASK = 4'hF;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] byte_t;
  typedef logic [CNT_W-1:0]  cnt_t;
endpackage

// File: rtl/data_2048x8.sv
// rtl/data_2048x8.sv - 2048x8 dual-port SRAM macro model, 1-cycle registered read, 2-bit write lanes
module data_2048x8
  import byte_stream_fifo_pkg::*;
(
  input  logic              R0_clk,
  input  logic              R0_en,
  input  addr_t             R0_addr,
  output byte_t             R0_data,
  input  logic              W0_clk,
  input  logic              W0_en,
  input  addr_t             W0_addr,
  input  byte_t             W0_data,
  input  logic [MASK_W-1:0] W0_mask
);
  byte_t mem_q [DEPTH];
  byte_t rdata_q;

  always_ff @(posedge W0_clk) begin
    if (W0_en) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (W0_mask[i]) mem_q[W0_addr][2*i +: 2] <= W0_data[2*i +: 2];
      end
    end
  end

  always_ff @(posedge R0_clk) begin
    if (R0_en) rdata_q <= mem_q[R0_addr];
  end

  assign R0_data = rdata_q;
endmodule

// File: rtl/fifo_out_skid.sv
// rtl/fifo_out_skid.sv - 2-entry ordered output buffer absorbing the SRAM read latency
module fifo_out_skid
  import byte_stream_fifo_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       cap_valid,
  input  byte_t      cap_data,
  input  logic       out_ready,
  output logic       out_valid,
  output byte_t      out_data,
  output logic       pop,
  output logic [1:0] occ
);
  byte_t      e0_q, e0_d, e1_q, e1_d;
  logic [1:0] occ_q, occ_d;

  assign out_valid = (occ_q != 2'd0);
  assign out_data  = e0_q;
  assign pop       = out_valid & out_ready;
  assign occ       = occ_q;

  // Pop shifts first, then the capture lands in the first free slot after the shift.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    occ_d = occ_q;
    if (pop) begin
      e0_d  = e1_q;
      occ_d = occ_q - 2'd1;
    end
    if (cap_valid) begin
      if (occ_d == 2'd0) e0_d = cap_data;
      else               e1_d = cap_data;
      occ_d = occ_d + 2'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
    end
  end
endmodule

// File: rtl/byte_stream_fifo_ctrl.sv
// rtl/byte_stream_fifo_ctrl.sv - ready/valid byte FIFO over a 2048x8 SRAM with a 2-entry output buffer
module byte_stream_fifo_ctrl
  import byte_stream_fifo_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  byte_t             in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output byte_t             out_data,
  output cnt_t              count,
  output addr_t             mem_R0_addr,
  output logic              mem_R0_en,
  output logic              mem_R0_clk,
  input  byte_t             mem_R0_data,
  output addr_t             mem_W0_addr,
  output logic              mem_W0_en,
  output logic              mem_W0_clk,
  output byte_t             mem_W0_data,
  output logic [MASK_W-1:0] mem_W0_mask
);
  addr_t      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cnt_t       mem_count_q, mem_count_d, count_q, count_d;
  logic       inflight_q, inflight_d, in_ready_q, in_ready_d;
  logic       push, issue, pop;
  logic [1:0] buf_occ;

  assign push = in_valid & in_ready_q;
  // mem_count_q excludes this cycle's write, so a byte is never read in the cycle it lands.
  assign issue = (mem_count_q != '0) &&
                 (({1'b0, buf_occ} + {2'b00, inflight_q} - {2'b00, pop}) < 3'd2);

  always_comb begin
    wr_ptr_d    = push  ? wr_ptr_q + addr_t'(1) : wr_ptr_q;
    rd_ptr_d    = issue ? rd_ptr_q + addr_t'(1) : rd_ptr_q;
    mem_count_d = mem_count_q + cnt_t'(push) - cnt_t'(issue);
    count_d     = count_q + cnt_t'(push) - cnt_t'(pop);
    inflight_d  = issue;
    in_ready_d  = (mem_count_d < cnt_t'(DEPTH));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      count_q     <= '0;
      inflight_q  <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      in_ready_q  <= in_ready_d;
    end
  end

  fifo_out_skid u_skid (
    .clock     (clock),
    .reset     (reset),
    .cap_valid (inflight_q),
    .cap_data  (mem_R0_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .pop       (pop),
    .occ       (buf_occ)
  );

  assign in_ready    = in_ready_q;
  assign count       = count_q;
  assign mem_R0_clk  = clock;
  assign mem_R0_en   = issue;
  assign mem_R0_addr = rd_ptr_q;
  assign mem_W0_clk  = clock;
  assign mem_W0_en   = push;
  assign mem_W0_addr = wr_ptr_q;
  assign mem_W0_data = in_data;
  assign mem_W0_mask = FULL_MASK;
endmodule

// File: tb/tb_byte_stream_fifo_ctrl.sv
// tb/tb_byte_stream_fifo_ctrl.sv - directed self-checking bench for byte_stream_fifo_ctrl with the SRAM model
module tb_byte_stream_fifo_ctrl;
  import byte_stream_fifo_pkg::*;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0, out_ready = 1'b0;
  logic              in_ready, out_valid;
  byte_t             in_data = '0, out_data;
  cnt_t              count;
  addr_t             r0_addr, w0_addr;
  logic              r0_en, r0_clk, w0_en, w0_clk;
  byte_t             r0_data, w0_data;
  logic [MASK_W-1:0] w0_mask;

  int    n_cmp = 0, n_mis = 0, cyc = 0;
  byte_t got[$];
  int    pop_cyc[$];

  always #5 clock = ~clock;

  byte_stream_fifo_ctrl dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count),
    .mem_R0_addr(r0_addr), .mem_R0_en(r0_en), .mem_R0_clk(r0_clk), .mem_R0_data(r0_data),
    .mem_W0_addr(w0_addr), .mem_W0_en(w0_en), .mem_W0_clk(w0_clk),
    .mem_W0_data(w0_data), .mem_W0_mask(w0_mask)
  );

  data_2048x8 u_mem (
    .R0_clk(r0_clk), .R0_en(r0_en), .R0_addr(r0_addr), .R0_data(r0_data),
    .W0_clk(w0_clk), .W0_en(w0_en), .W0_addr(w0_addr), .W0_data(w0_data), .W0_mask(w0_mask)
  );

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      got.push_back(out_data);
      pop_cyc.push_back(cyc);
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b1;
    next_cycle(); next_cycle();
    @(negedge clock);
    n_cmp++; if (in_ready !== 1'b0) begin n_mis++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (count !== 12'd0) begin n_mis++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (w0_en !== 1'b0 || r0_en !== 1'b0) begin n_mis++; $display("FAIL reset_mem_en got w=%b r=%b want 0 0", w0_en, r0_en); end
    next_cycle();
    reset = 1'b0; in_valid = 1'b0;
    next_cycle();
    @(negedge clock);
    n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    next_cycle();
  endtask

  task automatic test_single();
    got.delete(); pop_cyc.delete();
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    @(negedge clock);
    n_cmp++; if (w0_en !== 1'b1 || w0_addr !== 11'd0) begin n_mis++; $display("FAIL single_w0 got en=%b addr=%0d want 1 0", w0_en, w0_addr); end
    n_cmp++; if (w0_data !== 8'hA5 || w0_mask !== 4'hF) begin n_mis++; $display("FAIL single_w0_data got %h/%h want a5/f", w0_data, w0_mask); end
    n_cmp++; if (r0_en !== 1'b0) begin n_mis++; $display("FAIL single_no_same_cycle_read got %b want 0", r0_en); end
    next_cycle();
    in_valid = 1'b0;
    @(negedge clock);
    n_cmp++; if (r0_en !== 1'b1 || r0_addr !== 11'd0) begin n_mis++; $display("FAIL single_r0 got en=%b addr=%0d want 1 0", r0_en, r0_addr); end
    n_cmp++; if (count !== 12'd1) begin n_mis++; $display("FAIL single_count_t1 got %0d want 1", count); end
    next_cycle();
    @(negedge clock);
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL single_valid_t2 got %b want 0", out_valid); end
    next_cycle();
    @(negedge clock);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin n_mis++; $display("FAIL single_out_t3 got v=%b d=%h want 1 a5", out_valid, out_data); end
    next_cycle();
    @(negedge clock);
    n_cmp++; if (out_valid !== 1'b0 || count !== 12'd0) begin n_mis++; $display("FAIL single_after_pop got v=%b cnt=%0d want 0 0", out_valid, count); end
    next_cycle();
  endtask

  task automatic test_stream();
    int maxc, bad, first;
    got.delete(); pop_cyc.delete();
    maxc = 0; bad = 0; first = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_data = byte_t'(i);
      @(negedge clock);
      if (int'(count) > maxc) maxc = int'(count);
      n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL stream_in_ready idx %0d got %b want 1", i, in_ready); end
      next_cycle();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 50 && got.size() < 100; k++) begin
      @(negedge clock);
      if (int'(count) > maxc) maxc = int'(count);
      next_cycle();
    end
    n_cmp++; if (got.size() != 100) begin n_mis++; $display("FAIL stream_size got %0d want 100", got.size()); end
    for (int i = 0; i < got.size(); i++) if (got[i] !== byte_t'(i)) begin if (bad == 0) first = i; bad++; end
    n_cmp++; if (bad != 0) begin n_mis++; $display("FAIL stream_data idx %0d got %h want %h", first, got[first], byte_t'(first)); end
    n_cmp++; if (maxc != 3) begin n_mis++; $display("FAIL stream_max_count got %0d want 3", maxc); end
    if (pop_cyc.size() == 100) begin
      n_cmp++; if (pop_cyc[99] - pop_cyc[0] != 99) begin n_mis++; $display("FAIL stream_bubbles got span %0d want 99", pop_cyc[99] - pop_cyc[0]); end
    end
  endtask

  task automatic test_backpressure();
    int acc, bad, first;
    got.delete(); pop_cyc.delete();
    acc = 0; bad = 0; first = 0;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int g = 0; g < 2200 && acc < 2050; g++) begin
      in_data = byte_t'(acc);
      @(negedge clock);
      if (in_ready) acc++;
      next_cycle();
    end
    in_valid = 1'b0;
    n_cmp++; if (acc != 2050) begin n_mis++; $display("FAIL bp_accepts got %0d want 2050", acc); end
    @(negedge clock);
    n_cmp++; if (in_ready !== 1'b0) begin n_mis++; $display("FAIL bp_full_in_ready got %b want 0", in_ready); end
    n_cmp++; if (count !== 12'd2050) begin n_mis++; $display("FAIL bp_count got %0d want 2050", count); end
    n_cmp++; if (dut.mem_count_q !== 12'd2048) begin n_mis++; $display("FAIL bp_mem_count got %0d want 2048", dut.mem_count_q); end
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h00 || r0_en !== 1'b0) begin n_mis++; $display("FAIL bp_head got v=%b d=%h r0=%b want 1 00 0", out_valid, out_data, r0_en); end
    next_cycle();
    out_ready = 1'b1;
    @(negedge clock);
    n_cmp++; if (in_ready !== 1'b0 || r0_en !== 1'b1) begin n_mis++; $display("FAIL bp_first_issue got rdy=%b r0=%b want 0 1", in_ready, r0_en); end
    next_cycle();
    @(negedge clock);
    n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL bp_ready_after_issue got %b want 1", in_ready); end
    for (int k = 0; k < 2300 && got.size() < 2050; k++) next_cycle();
    next_cycle();
    n_cmp++; if (got.size() != 2050) begin n_mis++; $display("FAIL bp_drain_size got %0d want 2050", got.size()); end
    for (int i = 0; i < got.size(); i++) if (got[i] !== byte_t'(i)) begin if (bad == 0) first = i; bad++; end
    n_cmp++; if (bad != 0) begin n_mis++; $display("FAIL bp_data idx %0d got %h want %h", first, got[first], byte_t'(first)); end
    @(negedge clock);
    n_cmp++; if (count !== 12'd0) begin n_mis++; $display("FAIL bp_final_count got %0d want 0", count); end
    next_cycle();
  endtask

  task automatic test_wrap();
    int pushed, bad, first;
    logic saw_top, wrapped;
    got.delete(); pop_cyc.delete();
    pushed = 0; bad = 0; first = 0; saw_top = 1'b0; wrapped = 1'b0;
    for (int k = 0; k < 20000 && got.size() < 3000; k++) begin
      in_valid  = (pushed < 3000) && ($urandom_range(0, 3) != 0);
      in_data   = byte_t'(pushed);
      out_ready = ($urandom_range(0, 1) == 1);
      @(negedge clock);
      if (w0_en && w0_addr == 11'd2047) saw_top = 1'b1;
      if (saw_top && w0_en && w0_addr == 11'd0) wrapped = 1'b1;
      if (in_valid && in_ready) pushed++;
      next_cycle();
    end
    in_valid = 1'b0;
    n_cmp++; if (wrapped !== 1'b1) begin n_mis++; $display("FAIL wrap_pointer got %b want 1", wrapped); end
    n_cmp++; if (got.size() != 3000) begin n_mis++; $display("FAIL wrap_size got %0d want 3000", got.size()); end
    for (int i = 0; i < got.size(); i++) if (got[i] !== byte_t'(i)) begin if (bad == 0) first = i; bad++; end
    n_cmp++; if (bad != 0) begin n_mis++; $display("FAIL wrap_data idx %0d got %h want %h", first, got[first], byte_t'(first)); end
  endtask

  task automatic test_stall();
    int pushed, bad, first;
    logic held;
    byte_t held_d;
    got.delete(); pop_cyc.delete();
    pushed = 0; bad = 0; first = 0; held = 1'b0; held_d = '0;
    for (int k = 0; k < 400 && got.size() < 30; k++) begin
      in_valid  = (pushed < 30);
      in_data   = byte_t'(8'h40 + pushed);
      out_ready = (k % 3 == 0);
      @(negedge clock);
      if (held) begin
        n_cmp++; if (out_valid !== 1'b1 || out_data !== held_d) begin n_mis++; $display("FAIL stall_stable cyc %0d got v=%b d=%h want 1 %h", k, out_valid, out_data, held_d); end
      end
      held = out_valid && !out_ready; held_d = out_data;
      if (in_valid && in_ready) pushed++;
      next_cycle();
    end
    in_valid = 1'b0;
    n_cmp++; if (got.size() != 30) begin n_mis++; $display("FAIL stall_size got %0d want 30", got.size()); end
    for (int i = 0; i < got.size(); i++) if (got[i] !== byte_t'(8'h40 + i)) begin if (bad == 0) first = i; bad++; end
    n_cmp++; if (bad != 0) begin n_mis++; $display("FAIL stall_data idx %0d got %h want %h", first, got[first], byte_t'(8'h40 + first)); end
  endtask

  task automatic test_reset_mid();
    got.delete(); pop_cyc.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = byte_t'(8'h50 + i);
      next_cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    next_cycle();
    out_ready = 1'b0;
    n_cmp++; if (dut.inflight_q !== 1'b1 || count !== 12'd4) begin n_mis++; $display("FAIL midrst_pre got inflight=%b cnt=%0d want 1 4", dut.inflight_q, count); end
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || count !== 12'd0) begin n_mis++; $display("FAIL midrst_async got v=%b cnt=%0d want 0 0", out_valid, count); end
    next_cycle();
    reset = 1'b0;
    got.delete(); pop_cyc.delete();
    next_cycle();
    in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b1;
    @(negedge clock);
    n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    next_cycle();
    in_valid = 1'b0;
    @(negedge clock);
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL midrst_valid_t1 got %b want 0", out_valid); end
    next_cycle();
    @(negedge clock);
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL midrst_valid_t2 got %b want 0", out_valid); end
    next_cycle();
    @(negedge clock);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h3C) begin n_mis++; $display("FAIL midrst_out_t3 got v=%b d=%h want 1 3c", out_valid, out_data); end
    for (int k = 0; k < 10; k++) next_cycle();
    n_cmp++; if (got.size() != 1) begin n_mis++; $display("FAIL midrst_only_one got %0d bytes want 1", got.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_wrap();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/byte_stream_fifo_ctrl.md
Name: byte_stream_fifo_ctrl

Overview:
- Ready/valid byte FIFO controller that owns the 2048x8 dual-port SRAM macro (`data_2048x8`).
- Drives the macro's R0/W0 ports and hides its 1-cycle read latency behind a 2-entry output buffer.
- Sits between the upstream byte producer and the downstream consumer in the data path.

Parameters:
DEPTH, 2048, SRAM entries (power of two)
ADDR_W, 11, log2(DEPTH)
DATA_W, 8, byte width
MASK_W, 4, SRAM write-mask bits (2-bit lanes)
CNT_W, 12, occupancy counter width; must hold DEPTH+2

Ports:
clock  in  1  single clock; drives all state and both SRAM clocks
reset  in  1  asynchronous, active-high reset
in_valid  in  1  producer has a byte
in_ready  out  1  FIFO accepts a byte this cycle
in_data  in  DATA_W  producer byte
out_valid  out  1  head byte available
out_ready  in  1  consumer takes head byte
out_data  out  DATA_W  head byte
count  out  CNT_W  total bytes held (SRAM + in-flight + buffer)
mem_R0_addr / mem_R0_en / mem_R0_clk  out  ADDR_W/1/1  SRAM read port; clk = clock
mem_R0_data  in  DATA_W  SRAM read data, valid the cycle after R0_en
mem_W0_addr / mem_W0_en / mem_W0_clk  out  ADDR_W/1/1  SRAM write port; clk = clock
mem_W0_data / mem_W0_mask  out  DATA_W/MASK_W  write byte; mask is always 4'hF

Behaviour:
- Clock/reset: one clock (`clock`). `reset` is asynchronous and active-high.
- Reset values:
  - wr_ptr, rd_ptr, mem_count, inflight, buffer occupancy, count: 0.
  - out_valid = 0; in_ready = 0 while reset is high; mem_*_en = 0.
  - SRAM contents are not cleared. Stale data must never reach out_data.
- Push: occurs when in_valid & in_ready. Same cycle: W0_en=1, W0_addr=wr_ptr, W0_data=in_data, W0_mask=4'hF. wr_ptr increments mod DEPTH.
- in_ready = (mem_count < DEPTH). It is purely registered and does not depend on a read issued in the same cycle.
- Read issue: R0_en=1, R0_addr=rd_ptr when both of these hold:
  - mem_count > 0, counting only entries written in earlier cycles. A same-cycle write is never read.
  - (buf_occ + inflight - pop) < 2.
  - On issue, rd_ptr increments mod DEPTH and mem_count decrements. The slot is free for writing from the next cycle.
- Capture: inflight is set the cycle after issue. In that cycle mem_R0_data is written into the output buffer, so out_valid rises one cycle later.
- Output buffer: 2-entry FIFO, order preserved; head drives out_data.
  - Pop = out_valid & out_ready.
  - out_data is stable while out_valid & !out_ready.
- Latency: push in cycle t on an empty FIFO → read issue t+1 → R0 data t+2 → out_valid t+3.
- Throughput: 1 byte/cycle sustained when out_ready is held high.
- mem_count: +1 on push, -1 on issue; a simultaneous push and issue leaves it unchanged.
- count: +1 on push, -1 on pop; a simultaneous push and pop leaves it unchanged. Max value is DEPTH+2 = 2050.
- Wrap-around: pointers roll 2047→0 without a bubble.
- Full: mem_count == DEPTH holds in_ready low. in_ready rises the cycle after the first issue.
- Empty: out_valid = 0 and out_data is don't-care. mem_R0_data is ignored unless inflight is set.
- Reset asserted mid-operation: all state clears asynchronously. Any in-flight read is discarded and out_valid drops immediately.

Decomposition:
- Package byte_stream_fifo_pkg: DEPTH, ADDR_W, DATA_W, MASK_W, CNT_W, the full-mask constant 4'hF, typedefs addr_t/byte_t/cnt_t.
- One sub-module, fifo_out_skid: the 2-entry output buffer, with a capture input, pop handshake and occupancy output.
- The top level holds pointers, counters, issue logic and the SRAM port mapping. The bench instantiates data_2048x8 alongside it.

Test Plan:
- Single byte: reset, push 8'hA5 at t0 with out_ready=1 → W0_en t0 addr 0, R0_en t1 addr 0, out_valid t3 data 8'hA5, count 1→0 after pop.
- Streaming: push 0..99 back-to-back with out_ready=1 → out_data 0..99 in order, no bubbles after the first, count never exceeds 3.
- Backpressure: out_ready=0, push 2050 bytes → in_ready low after 2050 accepts, count=2050, mem_count=2048. Set out_ready=1 → in_ready high the cycle after the first issue; all bytes drain in order.
- Wrap: push/pop 3000 incrementing bytes (mod 256) with random out_ready → data matches the scoreboard; pointers pass 2047→0 with no loss.
- Stall stability: out_ready toggling 1-of-3 cycles → out_data is constant while out_valid & !out_ready; no duplicated or dropped bytes.
- Reset mid-stream: assert reset with 5 bytes queued and one read in flight → out_valid=0 and count=0 immediately. After release, push 8'h3C → only 8'h3C emerges, at +3 cycles.
